// File: rtl/led_seq_pkg.sv
// Shared encodings, entry patterns and pattern-step helpers for the LED mode sequencer.
package led_seq_pkg;

    localparam int unsigned PAT_W = 4;

    typedef enum logic [1:0] {
        MODE_OFF    = 2'd0,
        MODE_TOGGLE = 2'd1,
        MODE_CHASE  = 2'd2,
        MODE_COUNT  = 2'd3
    } mode_e;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_PAUSE = 1'b1
    } run_state_e;

    localparam logic [PAT_W-1:0] ENTRY_OFF    = 4'b0000;
    localparam logic [PAT_W-1:0] ENTRY_TOGGLE = 4'b0000;
    localparam logic [PAT_W-1:0] ENTRY_CHASE  = 4'b1000;
    localparam logic [PAT_W-1:0] ENTRY_COUNT  = 4'b0000;

    // Counter width for a 0..limit-1 counter, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned limit);
        return (limit > 1) ? $clog2(limit) : 1;
    endfunction

    function automatic logic [PAT_W-1:0] entry_pattern(input mode_e mode);
        logic [PAT_W-1:0] pat;
        pat = ENTRY_OFF;
        case (mode)
            MODE_OFF:    pat = ENTRY_OFF;
            MODE_TOGGLE: pat = ENTRY_TOGGLE;
            MODE_CHASE:  pat = ENTRY_CHASE;
            MODE_COUNT:  pat = ENTRY_COUNT;
            default:     pat = ENTRY_OFF;
        endcase
        return pat;
    endfunction

    function automatic logic [PAT_W-1:0] next_pattern(input mode_e mode,
                                                       input logic [PAT_W-1:0] pat);
        logic [PAT_W-1:0] nxt;
        nxt = '0;
        case (mode)
            MODE_OFF:    nxt = '0;
            MODE_TOGGLE: nxt = ~pat;
            MODE_CHASE:  nxt = {pat[0], pat[PAT_W-1:1]};
            MODE_COUNT:  nxt = pat + PAT_W'(1);
            default:     nxt = '0;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/switch_debounce.sv
// One switch: 2-flop synchronizer, optional counter filter (LED_SEQ_DEBOUNCE_EN), release pulse.
module switch_debounce
    import led_seq_pkg::*;
#(
    parameter int unsigned DEBOUNCE_LIMIT = 250000
) (
    input  logic clk,
    input  logic rst,
    input  logic switch_raw,
    output logic release_c
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic level_q, level_d;
    logic level_dly_q, level_dly_d;

    always_comb begin
        sync1_d     = switch_raw;
        sync2_d     = sync1_q;
        level_dly_d = level_q;
    end

`ifdef LED_SEQ_DEBOUNCE_EN
    localparam int unsigned      CNT_W   = cnt_width(DEBOUNCE_LIMIT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_LIMIT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Level flips only after the synced input has disagreed for DEBOUNCE_LIMIT cycles.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_MAX) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic unused_debounce_limit;

    always_comb begin
        level_d               = sync2_q;
        unused_debounce_limit = (DEBOUNCE_LIMIT == 32'd0);
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            level_q     <= 1'b0;
            level_dly_q <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            level_q     <= level_d;
            level_dly_q <= level_dly_d;
        end
    end

    assign release_c = level_dly_q & ~level_q;

endmodule

// File: rtl/led_mode_sequencer.sv
// Four-LED pattern sequencer: mode select, run/pause and single step from three switches.
// Switch filtering is enabled by LED_SEQ_DEBOUNCE_EN.
module led_mode_sequencer
    import led_seq_pkg::*;
#(
    parameter int unsigned DEBOUNCE_LIMIT = 250000,
    parameter int unsigned STEP_LIMIT     = 6250000
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic       i_Switch_1,
    input  logic       i_Switch_2,
    input  logic       i_Switch_3,
    output logic       o_LED_1,
    output logic       o_LED_2,
    output logic       o_LED_3,
    output logic       o_LED_4,
    output logic [1:0] o_Mode,
    output logic       o_Paused
);

    localparam int unsigned       STEP_W   = cnt_width(STEP_LIMIT);
    localparam logic [STEP_W-1:0] STEP_MAX = STEP_W'(STEP_LIMIT - 1);

    logic release_1_c, release_2_c, release_3_c;
    logic tick_c;

    mode_e             mode_q, mode_d;
    run_state_e        state_q, state_d;
    logic [PAT_W-1:0]  pattern_q, pattern_d;
    logic [STEP_W-1:0] step_cnt_q, step_cnt_d;

    switch_debounce #(.DEBOUNCE_LIMIT(DEBOUNCE_LIMIT)) u_sw1 (
        .clk        (i_Clk),
        .rst        (i_Rst),
        .switch_raw (i_Switch_1),
        .release_c  (release_1_c)
    );

    switch_debounce #(.DEBOUNCE_LIMIT(DEBOUNCE_LIMIT)) u_sw2 (
        .clk        (i_Clk),
        .rst        (i_Rst),
        .switch_raw (i_Switch_2),
        .release_c  (release_2_c)
    );

    switch_debounce #(.DEBOUNCE_LIMIT(DEBOUNCE_LIMIT)) u_sw3 (
        .clk        (i_Clk),
        .rst        (i_Rst),
        .switch_raw (i_Switch_3),
        .release_c  (release_3_c)
    );

    // Events resolve in priority order: mode change, run/pause, single step, timer tick.
    always_comb begin
        mode_d     = mode_q;
        state_d    = state_q;
        pattern_d  = pattern_q;
        step_cnt_d = step_cnt_q;
        tick_c     = (state_q == ST_RUN) && (step_cnt_q == STEP_MAX);

        if (state_q == ST_RUN) begin
            step_cnt_d = tick_c ? '0 : step_cnt_q + STEP_W'(1);
        end

        if (release_1_c) begin
            mode_d     = mode_e'(mode_q + 2'd1);
            pattern_d  = entry_pattern(mode_d);
            step_cnt_d = '0;
            state_d    = ST_RUN;
        end else if (release_2_c) begin
            state_d = (state_q == ST_RUN) ? ST_PAUSE : ST_RUN;
        end else if (release_3_c && (state_q == ST_PAUSE)) begin
            pattern_d = next_pattern(mode_q, pattern_q);
        end else if (tick_c) begin
            pattern_d = next_pattern(mode_q, pattern_q);
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            mode_q     <= MODE_OFF;
            state_q    <= ST_RUN;
            pattern_q  <= '0;
            step_cnt_q <= '0;
        end else begin
            mode_q     <= mode_d;
            state_q    <= state_d;
            pattern_q  <= pattern_d;
            step_cnt_q <= step_cnt_d;
        end
    end

    assign {o_LED_1, o_LED_2, o_LED_3, o_LED_4} = pattern_q;
    assign o_Mode   = mode_q;
    assign o_Paused = (state_q == ST_PAUSE);

endmodule

// File: tb/tb_led_mode_sequencer.sv
// Directed bench for led_mode_sequencer with DEBOUNCE_LIMIT=4, STEP_LIMIT=8; follows LED_SEQ_DEBOUNCE_EN.
module tb_led_mode_sequencer;

`ifdef LED_SEQ_DEBOUNCE_EN
    localparam int         REL_LAT     = 7;        // raw fall to visible output change
    localparam logic [1:0] GLITCH_MODE = 2'd3;
    localparam logic [1:0] TICK_MODE   = 2'd1;
    localparam logic [3:0] TICK_ENTRY  = 4'b0000;
    localparam int         TO3         = 2;
`else
    localparam int         REL_LAT     = 4;
    localparam logic [1:0] GLITCH_MODE = 2'd0;
    localparam logic [1:0] TICK_MODE   = 2'd2;
    localparam logic [3:0] TICK_ENTRY  = 4'b1000;
    localparam int         TO3         = 1;
`endif

    logic       i_Clk = 1'b0;
    logic       i_Rst;
    logic       i_Switch_1, i_Switch_2, i_Switch_3;
    logic       o_LED_1, o_LED_2, o_LED_3, o_LED_4;
    logic [1:0] o_Mode;
    logic       o_Paused;
    logic [3:0] leds;

    int total = 0;
    int bad   = 0;

    led_mode_sequencer #(.DEBOUNCE_LIMIT(4), .STEP_LIMIT(8)) dut (
        .i_Clk      (i_Clk),
        .i_Rst      (i_Rst),
        .i_Switch_1 (i_Switch_1),
        .i_Switch_2 (i_Switch_2),
        .i_Switch_3 (i_Switch_3),
        .o_LED_1    (o_LED_1),
        .o_LED_2    (o_LED_2),
        .o_LED_3    (o_LED_3),
        .o_LED_4    (o_LED_4),
        .o_Mode     (o_Mode),
        .o_Paused   (o_Paused)
    );

    always #5 i_Clk = ~i_Clk;
    assign leds = {o_LED_1, o_LED_2, o_LED_3, o_LED_4};

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge i_Clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_mode(input string tag, input logic [1:0] exp);
        chk(tag, 7'(o_Mode), 7'(exp));
    endtask

    task automatic chk_leds(input string tag, input logic [3:0] exp);
        chk(tag, 7'(leds), 7'(exp));
    endtask

    task automatic chk_paused(input string tag, input logic exp);
        chk(tag, 7'(o_Paused), 7'(exp));
    endtask

    task automatic chk_zero(input string tag);
        chk(tag, {o_Mode, o_Paused, leds}, 7'd0);
    endtask

    task automatic set_sw(input int idx, input logic v);
        case (idx)
            1:       i_Switch_1 = v;
            2:       i_Switch_2 = v;
            3:       i_Switch_3 = v;
            default: ;
        endcase
    endtask

    // Press, hold, release; returns one cycle before the release takes effect.
    task automatic do_release(input int idx, input int hold);
        set_sw(idx, 1'b1);
        cycles(hold);
        set_sw(idx, 1'b0);
        cycles(REL_LAT - 1);
    endtask

    initial begin
        i_Rst = 1'b1;
        i_Switch_1 = 1'b0;
        i_Switch_2 = 1'b0;
        i_Switch_3 = 1'b0;
        cycles(2);
        chk_zero("reset_outputs");
        i_Rst = 1'b0;
        for (int i = 0; i < 40; i++) begin
            cycles(1);
            chk_zero("idle_off");
        end

        // Two mode advances land in CHASE, then the one-hot rotates every 8 cycles.
        do_release(1, 10);
        chk_mode("m1_before", 2'd0);
        cycles(1);
        chk_mode("m1_after", 2'd1);
        do_release(1, 10);
        chk_mode("m2_before", 2'd1);
        cycles(1);
        chk_mode("m2_after", 2'd2);
        chk_leds("chase_entry", 4'b1000);
        chk_paused("chase_run", 1'b0);
        cycles(7);
        chk_leds("chase_hold", 4'b1000);
        cycles(1);
        chk_leds("chase_1", 4'b0100);
        cycles(8);
        chk_leds("chase_2", 4'b0010);
        cycles(8);
        chk_leds("chase_3", 4'b0001);
        cycles(8);
        chk_leds("chase_wrap", 4'b1000);

        // Enter COUNT, pause two cycles later before any tick.
        set_sw(1, 1'b1);
        set_sw(2, 1'b1);
        cycles(10);
        set_sw(1, 1'b0);
        cycles(2);
        set_sw(2, 1'b0);
        cycles(REL_LAT - 3);
        chk_mode("m3_before", 2'd2);
        cycles(1);
        chk_mode("m3_after", 2'd3);
        chk_leds("count_entry", 4'b0000);
        cycles(1);
        chk_paused("pause_before", 1'b0);
        cycles(1);
        chk_paused("pause_after", 1'b1);
        chk_leds("pause_pattern", 4'b0000);

        for (int k = 1; k <= 5; k++) begin
            do_release(3, 6);
            chk_leds("step_before", 4'(k - 1));
            cycles(1);
            chk_leds("step_after", 4'(k));
        end
        for (int i = 0; i < 5; i++) begin
            cycles(10);
            chk_leds("paused_hold", 4'b0101);
            chk_paused("paused_state", 1'b1);
        end

        do_release(2, 6);
        chk_paused("resume_before", 1'b1);
        cycles(1);
        chk_paused("resume_after", 1'b0);
        chk_mode("resume_mode", 2'd3);

        // Two-cycle glitch: filtered out with debounce, a real release without.
        set_sw(1, 1'b1);
        cycles(2);
        set_sw(1, 1'b0);
        cycles(REL_LAT - 1);
        chk_mode("glitch_before", 2'd3);
        cycles(1);
        chk_mode("glitch_after", GLITCH_MODE);
        cycles(5);
        chk_mode("glitch_settled", GLITCH_MODE);

        // Switch 1 and 2 released together: mode wins, run/pause dropped.
        set_sw(1, 1'b1);
        set_sw(2, 1'b1);
        cycles(10);
        set_sw(1, 1'b0);
        set_sw(2, 1'b0);
        cycles(REL_LAT - 1);
        chk_mode("coinc_before", GLITCH_MODE);
        cycles(1);
        chk_mode("coinc_mode", 2'(GLITCH_MODE + 2'd1));
        chk_paused("coinc_paused", 1'b0);
        chk_leds("coinc_entry", 4'b0000);

        // Switch 2 release lands on the 8th cycle after a mode change, i.e. on a tick.
        set_sw(2, 1'b1);
        set_sw(1, 1'b1);
        cycles(10);
        set_sw(1, 1'b0);
        cycles(8);
        set_sw(2, 1'b0);
        cycles(REL_LAT - 1);
        chk_mode("tick_mode", TICK_MODE);
        chk_paused("tick_before", 1'b0);
        chk_leds("tick_entry", TICK_ENTRY);
        cycles(1);
        chk_paused("tick_paused", 1'b1);
        chk_leds("tick_suppressed", TICK_ENTRY);
        cycles(20);
        chk_leds("tick_hold", TICK_ENTRY);
        chk_paused("tick_hold_paused", 1'b1);

        // Reset mid-step in COUNT with pattern 0110 while switch 2 is held.
        for (int i = 0; i < TO3; i++) begin
            do_release(1, 6);
            cycles(1);
        end
        chk_mode("rst_mode3", 2'd3);
        chk_paused("rst_run", 1'b0);
        chk_leds("rst_entry", 4'b0000);
        cycles(39);
        set_sw(2, 1'b1);
        cycles(10);
        chk_leds("rst_pattern", 4'b0110);
        i_Rst = 1'b1;
        cycles(1);
        chk_zero("rst_outputs");
        i_Rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cycles(1);
            chk_zero("rst_held_sw2");
        end
        set_sw(2, 1'b0);
        cycles(REL_LAT - 1);
        chk_paused("post_rst_before", 1'b0);
        cycles(1);
        chk_paused("post_rst_pause", 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
